// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, sequencer state type and GF(2^8) xtime
package aes_pkg;
  localparam int ROUNDS = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_LAST = 8'h36;
  typedef enum logic {IDLE, ROUND} state_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
endpackage

// File: rtl/aes_pipe_reg_start_if.sv
// aes_pipe_reg_start_if: plaintext/key valid-ready entry handshake
interface aes_pipe_reg_start_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] data_in;
  logic [127:0] key_in;
  modport master(output in_valid, data_in, key_in, input in_ready);
  modport slave(input in_valid, data_in, key_in, output in_ready);
endinterface

// File: rtl/aes_pipe_reg_start.sv
// aes_pipe_reg_start: AES-128 entry register and round/Rcon sequencer
// AES_PIPE_START_ARK0_EN folds the round-0 AddRoundKey into the entry load.
module aes_pipe_reg_start
  import aes_pkg::*;
(
  input  logic clock,
  input  logic reset,
  aes_pipe_reg_start_if.slave bus,
  input  logic [127:0] fb_in,
  input  logic [127:0] fb_key_in,
  output logic [7:0] Rcon_out,
  output logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7,
  output logic [7:0] out8, out9, outA, outB, outC, outD, outE, outF,
  output logic [127:0] key_out,
  output logic busy
);
  localparam int CW = $clog2(ROUNDS + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [127:0] lanes;
  logic [127:0] load;
`ifdef AES_PIPE_START_ARK0_EN
  assign load = bus.data_in ^ bus.key_in;
`else
  assign load = bus.data_in;
`endif
  assign bus.in_ready = (state == IDLE) && !reset;
  assign {outF, outE, outD, outC, outB, outA, out9, out8,
          out7, out6, out5, out4, out3, out2, out1, out0} = lanes;
  // Rcon_out drops to zero on the terminal edge so the end register never re-captures
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lanes <= '0;
      key_out <= '0;
      Rcon_out <= 8'h00;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        state <= ROUND;
        cnt <= CW'(1);
        lanes <= load;
        key_out <= bus.key_in;
        Rcon_out <= RCON_INIT;
        busy <= 1'b1;
      end
    end else if (cnt == CW'(ROUNDS)) begin
      state <= IDLE;
      cnt <= '0;
      Rcon_out <= 8'h00;
      busy <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      lanes <= fb_in;
      key_out <= fb_key_in;
      Rcon_out <= xtime(Rcon_out);
    end
  end
endmodule
